// File: rtl/fifo_wptr_ctrl_if.sv
// Write-side port bundle of the dual-clock FIFO pointer controller.
// slave = the pointer controller, master = the producer / test driver.
interface fifo_wptr_ctrl_if #(
  parameter int AWIDTH = 3
);
  // Handshake: wrreq_i is the producer's valid, ~full_o is the ready.
  // A word is transferred on a clk_i edge where wr_en_o (= wrreq_i & ~full_o) is high.
  // A word that is not accepted must be held and retried by the producer.
  logic              wrreq_i;
  logic [AWIDTH:0]   rptr_gray_sync_i;
  logic              wr_en_o;
  logic [AWIDTH-1:0] waddr_o;
  logic [AWIDTH:0]   wptr_gray_o;
  logic              full_o;
  logic              almost_full_o;
  logic [AWIDTH:0]   usedw_o;
  logic              ovf_o;

  modport slave (
    input  wrreq_i,
    input  rptr_gray_sync_i,
    output wr_en_o,
    output waddr_o,
    output wptr_gray_o,
    output full_o,
    output almost_full_o,
    output usedw_o,
    output ovf_o
  );

  modport master (
    output wrreq_i,
    output rptr_gray_sync_i,
    input  wr_en_o,
    input  waddr_o,
    input  wptr_gray_o,
    input  full_o,
    input  almost_full_o,
    input  usedw_o,
    input  ovf_o
  );
endinterface

// File: rtl/fifo_wptr_ctrl.sv
// Write-domain pointer controller: gates writes, keeps binary/Gray write pointers,
// and derives full / almost-full / fill level / overflow against the synced read pointer.
module fifo_wptr_ctrl #(
  parameter int AWIDTH   = 3,
  parameter int AF_LEVEL = 6
) (
  input  logic             clk_i,
  input  logic             aclr_i,
  fifo_wptr_ctrl_if.slave  bus
);

  localparam logic [AWIDTH:0] AF_L = (AWIDTH + 1)'(AF_LEVEL);

  logic [AWIDTH:0] wbin_q, wbin_d;
  logic [AWIDTH:0] wgray_q, wgray_d;
  logic [AWIDTH:0] usedw_q, usedw_d;
  logic            full_q, full_d;
  logic            af_q, af_d;
  logic            ovf_q, ovf_d;
  logic            wr_en;
  logic [AWIDTH:0] rg;
  logic [AWIDTH:0] rbin;
  logic [AWIDTH:0] full_cmp;

  assign rg = bus.rptr_gray_sync_i;

  always_comb begin
    wr_en   = bus.wrreq_i & ~full_q;
    wbin_d  = wbin_q + {{AWIDTH{1'b0}}, wr_en};
    wgray_d = wbin_d ^ (wbin_d >> 1);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    rbin = '0;
    for (int i = 0; i <= AWIDTH; i++) begin
      rbin[i] = ^(rg >> i);
    end

    // Full when the write pointer is exactly one lap (2^AWIDTH) ahead of the read pointer.
    full_cmp = {~rg[AWIDTH:AWIDTH-1], rg[AWIDTH-2:0]};
    full_d   = (wgray_d == full_cmp);

    usedw_d = wbin_d - rbin;
    af_d    = (usedw_d >= AF_L);
    ovf_d   = ovf_q | (bus.wrreq_i & full_q);
  end

  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      usedw_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      usedw_q <= usedw_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.wr_en_o       = wr_en;
  assign bus.waddr_o       = wbin_q[AWIDTH-1:0];
  assign bus.wptr_gray_o   = wgray_q;
  assign bus.full_o        = full_q;
  assign bus.almost_full_o = af_q;
  assign bus.usedw_o       = usedw_q;
  assign bus.ovf_o         = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Bench for fifo_wptr_ctrl: directed steps plus random traffic against a
// count-based occupancy model (words written vs. read pointer position).
module tb_fifo_wptr_ctrl;
  localparam int AWIDTH   = 3;
  localparam int AF_LEVEL = 6;
  localparam int DEPTH    = 1 << AWIDTH;
  localparam int PMOD     = 1 << (AWIDTH + 1);

  // clock / reset
  logic clk  = 1'b0;
  logic aclr = 1'b1;
  always #5 clk = ~clk;

  fifo_wptr_ctrl_if #(.AWIDTH(AWIDTH)) bus ();

  fifo_wptr_ctrl #(.AWIDTH(AWIDTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk_i  (clk),
    .aclr_i (aclr),
    .bus    (bus)
  );

  // model: total accepted words, current read position, sticky overflow
  int   wr_cnt;
  int   rd_cnt;
  int   exp_used;
  logic exp_full;
  logic exp_af;
  logic exp_ovf;
  logic [AWIDTH-1:0] exp_q[$];

  int errors = 0;
  int checks = 0;

  logic [AWIDTH:0] prev_gray;
  logic seen_1000, seen_0000_after;
  int   max_used;
  int   hist0, hist1;

  function automatic logic [AWIDTH:0] to_gray(input int b);
    logic [AWIDTH:0] v;
    v = AWIDTH'(0) + (AWIDTH + 1)'(b % PMOD);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wr_cnt   = 0;
    rd_cnt   = 0;
    exp_used = 0;
    exp_full = 1'b0;
    exp_af   = 1'b0;
    exp_ovf  = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".usedw"}, 32'(bus.usedw_o), 32'(exp_used));
    chk({tag, ".full"}, 32'(bus.full_o), 32'(exp_full));
    chk({tag, ".af"}, 32'(bus.almost_full_o), 32'(exp_af));
    chk({tag, ".ovf"}, 32'(bus.ovf_o), 32'(exp_ovf));
    chk({tag, ".gray"}, 32'(bus.wptr_gray_o), 32'(to_gray(wr_cnt)));
  endtask

  // driver: one clock cycle; called at a negedge, returns at the next negedge
  task automatic cycle(input string tag, input logic w, input int rd);
    logic acc;
    bus.wrreq_i          = w;
    bus.rptr_gray_sync_i = to_gray(rd);
    prev_gray            = bus.wptr_gray_o;
    #1;
    acc = w & ~exp_full;
    chk({tag, ".wr_en"}, 32'(bus.wr_en_o), 32'(acc));
    if (acc) begin
      exp_q.push_back(AWIDTH'(wr_cnt % DEPTH));
      chk({tag, ".waddr"}, 32'(bus.waddr_o), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    if (w && exp_full) exp_ovf = 1'b1;
    if (acc) wr_cnt++;
    rd_cnt   = rd;
    exp_used = (wr_cnt - rd_cnt) % PMOD;
    exp_full = (exp_used == DEPTH);
    exp_af   = (exp_used >= AF_LEVEL);
    @(negedge clk);
    check_regs(tag);
    chk({tag, ".gray_1bit"}, 32'($countones(prev_gray ^ bus.wptr_gray_o) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    aclr = 1'b1;
    model_reset();
    @(negedge clk);
    bus.wrreq_i          = 1'b0;
    bus.rptr_gray_sync_i = '0;
    aclr = 1'b0;
  endtask

  initial begin
    bus.wrreq_i          = 1'b0;
    bus.rptr_gray_sync_i = '0;
    model_reset();

    // reset state
    @(negedge clk);
    #1;
    check_regs("reset");
    chk("reset.waddr", 32'(bus.waddr_o), 32'd0);
    @(negedge clk);
    aclr = 1'b0;

    // fill from empty
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 0);
    chk("fill.gray_end", 32'(bus.wptr_gray_o), 32'b1100);
    chk("fill.usedw_end", 32'(bus.usedw_o), 32'd8);
    chk("fill.full_end", 32'(bus.full_o), 32'd1);

    // overflow attempt while full
    cycle("ovf", 1'b1, 0);
    chk("ovf.sticky", 32'(bus.ovf_o), 32'd1);
    chk("ovf.usedw", 32'(bus.usedw_o), 32'd8);

    // drain release
    cycle("drain", 1'b0, 1);
    chk("drain.usedw", 32'(bus.usedw_o), 32'd7);
    chk("drain.af", 32'(bus.almost_full_o), 32'd1);

    // simultaneous write request and read advance while full (spec scenario from reset)
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b1, 0);
    cycle("simul", 1'b1, 1);
    chk("simul.ovf", 32'(bus.ovf_o), 32'd1);
    chk("simul.full", 32'(bus.full_o), 32'd0);
    chk("simul.usedw", 32'(bus.usedw_o), 32'd7);
    cycle("retry", 1'b1, 1);
    chk("retry.usedw", 32'(bus.usedw_o), 32'd8);

    // wrap-around with read pointer two cycles behind
    do_reset();
    hist0 = 0;
    hist1 = 0;
    seen_1000 = 1'b0;
    seen_0000_after = 1'b0;
    max_used = 0;
    for (int i = 0; i < 20; i++) begin
      int rd;
      rd    = hist1;
      hist1 = hist0;
      hist0 = wr_cnt + 1;
      cycle("wrap", 1'b1, rd);
      if (bus.wptr_gray_o == 4'b1000) seen_1000 = 1'b1;
      if (seen_1000 && bus.wptr_gray_o == 4'b0000) seen_0000_after = 1'b1;
      if (int'(bus.usedw_o) > max_used) max_used = int'(bus.usedw_o);
    end
    chk("wrap.seen_1000_then_0000", 32'(seen_0000_after), 32'd1);
    chk("wrap.max_used_le2", 32'(max_used <= 2), 32'd1);

    // random traffic; read position never passes written words
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int rd;
      rd = rd_cnt;
      if (rd < wr_cnt && $urandom_range(0, 99) < 45) rd = rd + 1;
      cycle("rand", 1'($urandom_range(0, 1)), rd);
    end

    // reset mid-operation: usedw=5, ovf=1
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle("fill3", 1'b1, 0);
    cycle("ovf3", 1'b1, 0);
    cycle("drain3", 1'b0, 3);
    chk("mid.usedw_pre", 32'(bus.usedw_o), 32'd5);
    chk("mid.ovf_pre", 32'(bus.ovf_o), 32'd1);
    #2;
    aclr = 1'b1;
    #1;
    model_reset();
    check_regs("midreset");
    chk("midreset.waddr", 32'(bus.waddr_o), 32'd0);
    @(negedge clk);
    bus.rptr_gray_sync_i = '0;
    aclr = 1'b0;
    cycle("post", 1'b1, 0);
    chk("post.gray", 32'(bus.wptr_gray_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_ctrl.md
# fifo_wptr_ctrl

Write-side pointer controller for the team's dual-clock FIFO. Runs entirely in the write clock domain and gates write requests into the FIFO memory. Maintains the binary and Gray write pointers and publishes the Gray write pointer for synchronization into the read domain. Derives full, almost-full, fill level and overflow status by comparing against the read pointer after it has been Gray-synchronized into this domain.

## Interface
- AWIDTH, 3: memory address width; FIFO depth = 2^AWIDTH; legal range AWIDTH >= 2.
- AF_LEVEL, 6: almost_full_o asserts when the fill level is >= AF_LEVEL; legal range 1..2^AWIDTH.

- clk_i  input  1  write-domain clock.
- aclr_i  input  1  reset, asynchronous, active-high.
- wrreq_i  input  1  write request from the producer.
- rptr_gray_sync_i  input  AWIDTH+1  read pointer in Gray code, already synchronized into clk_i.
- wr_en_o  output  1  memory write enable (combinational).
- waddr_o  output  AWIDTH  memory write address.
- wptr_gray_o  output  AWIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
- full_o  output  1  FIFO full (registered).
- almost_full_o  output  1  fill level >= AF_LEVEL (registered).
- usedw_o  output  AWIDTH+1  fill level as seen from the write side, 0..2^AWIDTH (registered).
- ovf_o  output  1  sticky overflow flag.

## Operation
- Internal state:
  - wbin: AWIDTH+1-bit binary write pointer; wraps modulo 2^(AWIDTH+1).
  - wgray: registered Gray form of wbin.
- Accept logic:
  - wr_en_o = wrreq_i & ~full_o.
  - waddr_o = wbin[AWIDTH-1:0].
- Next-pointer logic:
  - wbin_next = wbin + wr_en_o.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
- Read pointer conversion: rbin = Gray-to-binary of rptr_gray_sync_i (prefix XOR from the MSB down).
- On every clk_i edge the block registers:
  - wbin <= wbin_next.
  - wgray <= wgray_next.
  - full_o <= (wgray_next == {~rg[AWIDTH:AWIDTH-1], rg[AWIDTH-2:0]}), where rg = rptr_gray_sync_i.
  - usedw_o <= wbin_next - rbin, computed modulo 2^(AWIDTH+1).
  - almost_full_o <= (wbin_next - rbin) >= AF_LEVEL.
- Overflow:
  - ovf_o sets on any cycle with wrreq_i & full_o.
  - ovf_o stays set until aclr_i; there is no synchronous clear.
- A rejected write leaves wbin, wgray and memory untouched. The producer must retry.
- Flags are conservative:
  - The read pointer lags by the synchronizer latency, so full_o and usedw_o may overstate occupancy.
  - They never understate it.

## Timing
- Reset values (aclr_i high, asynchronous): wbin = 0, wptr_gray_o = 0, waddr_o = 0, full_o = 0, almost_full_o = 0, usedw_o = 0, ovf_o = 0.
- wr_en_o while in reset = wrreq_i, since full_o = 0; the producer holds off until aclr_i falls.
- Write latency:
  - An accepted write at edge N advances waddr_o and wptr_gray_o immediately after edge N.
  - The memory captures data at edge N using the pre-edge waddr_o.
- Full asserts in the cycle immediately after the edge that accepts the 2^AWIDTH-th outstanding word. There is no lookahead gap.
- Full deasserts one clk_i edge after rptr_gray_sync_i advances.
- Simultaneous write request and read-pointer advance while full:
  - The write is rejected, because full_o is still registered high.
  - ovf_o sets.
  - full_o clears at the same edge.
- Wrap-around: wbin rolls from 2^(AWIDTH+1)-1 to 0 with no glitch on full or usedw, because the subtraction is modulo.
- Reset mid-operation: all state clears at once regardless of the clock. A pending write is discarded.
- wptr_gray_o changes at most one bit per clock. This is required by the downstream synchronizer.

## Test plan
- Fill from empty:
  - Setup: AWIDTH=3, AF_LEVEL=6, rptr_gray_sync_i=0000, wrreq_i held high for 8 cycles.
  - Response: waddr_o steps 0..7; almost_full_o rises after the 6th write; full_o rises after the 8th write.
  - End state: wptr_gray_o=1100, usedw_o=8, wr_en_o=0.
- Overflow:
  - Stimulus: continue from full with wrreq_i high for 1 cycle.
  - Response: wr_en_o=0, ovf_o=1 and stays 1; wbin and usedw_o unchanged.
- Drain release:
  - Stimulus: from full, drive rptr_gray_sync_i to 0001 (rbin=1).
  - Response: next edge full_o=0, usedw_o=7; almost_full_o stays 1.
- Simultaneous event:
  - Stimulus: from full, wrreq_i=1 in the same cycle rptr_gray_sync_i changes to 0001.
  - Response: write rejected, ovf_o=1; next edge full_o=0, usedw_o=7, then the retried write is accepted.
- Wrap-around:
  - Stimulus: 20 writes, with rptr_gray_sync_i tracking the write pointer two cycles behind.
  - Response: wptr_gray_o passes 1000 then 0000 (wbin 15->0) with single-bit changes only; full_o never asserts; usedw_o stays <= 2.
- Reset mid-operation:
  - Stimulus: assert aclr_i asynchronously with usedw_o=5 and ovf_o=1.
  - Response: all outputs read 0 before the next clk_i edge; the first write after release uses waddr_o=0.
